// File: rtl/cdc_hs_launch.sv
// Source-domain launcher for a toggle req/ack CDC handshake: holds one word on tx_data,
// flips tx_req, and waits for the resynchronized remote ack toggle. Optional: CDC_LAUNCH_TIMEOUT_EN.
module cdc_hs_launch #(
    parameter int WD     = 8,
    parameter int RANK   = 2,
    parameter int RESETV = 0,
    parameter int TMO_W  = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [WD-1:0] s_data,
    output logic [WD-1:0] tx_data,
    output logic          tx_req,
    input  logic          ack_tgl_a,
    output logic          done,
    output logic          busy,
    output logic          err_tmo
);

    // Handshake: upstream word transfers on a clk edge where s_valid && s_ready.
    localparam int RK = (RANK < 2) ? 2 : ((RANK > 4) ? 4 : RANK);
    localparam logic [WD-1:0] DATA_RST = (RESETV != 0) ? {WD{1'b1}} : {WD{1'b0}};

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t state;

    (* ASYNC_REG = "TRUE" *) logic ack_meta;
    logic [RK-2:0] ack_pipe;
    logic          ack_s;

    assign ack_s = ack_pipe[RK-2];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ack_meta <= 1'b0;
            ack_pipe <= '0;
        end else begin
            ack_meta    <= ack_tgl_a;
            ack_pipe[0] <= ack_meta;
            for (int i = 1; i < RK - 1; i++) begin
                ack_pipe[i] <= ack_pipe[i-1];
            end
        end
    end

    // The transfer completes when the synchronized ack catches up with tx_req.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            tx_req  <= 1'b0;
            tx_data <= DATA_RST;
            done    <= 1'b0;
            busy    <= 1'b0;
            s_ready <= 1'b1;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (s_valid) begin
                        tx_data <= s_data;
                        tx_req  <= ~tx_req;
                        state   <= WAIT;
                        busy    <= 1'b1;
                        s_ready <= 1'b0;
                    end
                end
                WAIT: begin
                    if (ack_s == tx_req) begin
                        done    <= 1'b1;
                        state   <= IDLE;
                        busy    <= 1'b0;
                        s_ready <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    s_ready <= 1'b1;
                end
            endcase
        end
    end

`ifdef CDC_LAUNCH_TIMEOUT_EN
    logic [TMO_W-1:0] tmo_cnt;
    logic [TMO_W-1:0] tmo_nxt;
    logic             err_q;

    assign tmo_nxt = tmo_cnt + 1'b1;
    assign err_tmo = err_q;

    // Counts WAIT cycles without an ack; saturates at all-ones and latches the error.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
            err_q   <= 1'b0;
        end else if (state == IDLE) begin
            tmo_cnt <= '0;
        end else if ((ack_s != tx_req) && !(&tmo_cnt)) begin
            tmo_cnt <= tmo_nxt;
            if (&tmo_nxt) begin
                err_q <= 1'b1;
            end
        end
    end
`else
    assign err_tmo = 1'b0;
`endif

endmodule

// File: tb/tb_cdc_hs_launch.sv
// Bench for cdc_hs_launch: directed handshake scenarios plus randomized traffic against a
// cycle-level reference model; build with +define+CDC_LAUNCH_TIMEOUT_EN to cover the timeout.
module tb_cdc_hs_launch;

  localparam int WD      = 8;
  localparam int RANK    = 2;
  localparam int RESETV  = 1;
  localparam int TMO_W   = 4;
  localparam int TMO_MAX = (1 << TMO_W) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          s_valid;
  logic          s_ready;
  logic [WD-1:0] s_data;
  logic [WD-1:0] tx_data;
  logic          tx_req;
  logic          ack_tgl_a;
  logic          done;
  logic          busy;
  logic          err_tmo;

  always #5 clk = ~clk;

  cdc_hs_launch #(.WD(WD), .RANK(RANK), .RESETV(RESETV), .TMO_W(TMO_W)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .tx_data(tx_data), .tx_req(tx_req), .ack_tgl_a(ack_tgl_a), .done(done),
    .busy(busy), .err_tmo(err_tmo)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: ack_s is simply the ack input RANK edges earlier.
  bit            m_busy, m_req, m_done, m_err, m_accept;
  logic [WD-1:0] m_data;
  int            m_wait;
  bit            ack_hist[$];
  logic [WD-1:0] exp_q[$];

  task automatic model_reset();
    m_busy = 0; m_req = 0; m_done = 0; m_err = 0; m_wait = 0;
    m_data = (RESETV != 0) ? {WD{1'b1}} : {WD{1'b0}};
    ack_hist.delete();
    repeat (RANK) ack_hist.push_back(1'b0);
    exp_q.delete();
  endtask

  task automatic model_edge();
    bit old_ack;
    m_accept = 0;
    if (!rst_n) begin
      model_reset();
      return;
    end
    old_ack = ack_hist.pop_front();
    ack_hist.push_back(ack_tgl_a);
    m_done = 0;
    if (m_busy) begin
      if (old_ack == m_req) begin
        m_done = 1;
        m_busy = 0;
      end else begin
        m_wait++;
`ifdef CDC_LAUNCH_TIMEOUT_EN
        if (m_wait >= TMO_MAX) m_err = 1;
`endif
      end
    end else if (s_valid) begin
      m_data   = s_data;
      m_req    = !m_req;
      m_busy   = 1;
      m_wait   = 0;
      m_accept = 1;
      exp_q.push_back(s_data);
    end
  endtask

  task automatic compare_all();
    check("tx_data", tx_data, m_data);
    check("tx_req", tx_req, m_req);
    check("busy", busy, m_busy);
    check("s_ready", s_ready, !m_busy);
    check("done", done, m_done);
    check("err_tmo", err_tmo, m_err);
    if (m_done) begin
      if (exp_q.size() == 0) check("sb_underflow", 1, 0);
      else check("sb_word", tx_data, exp_q.pop_front());
    end
  endtask

  // Remote side: echoes tx_req onto the ack toggle after a programmable delay.
  bit loop_en  = 0;
  bit rand_dly = 0;
  int loop_dly = 0;
  int rem_cnt  = 0;

  task automatic responder();
    if (!loop_en) return;
    if (ack_tgl_a != tx_req) begin
      if (rem_cnt == 0) ack_tgl_a = tx_req;
      else rem_cnt--;
    end else begin
      rem_cnt = rand_dly ? $urandom_range(0, 6) : loop_dly;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    compare_all();
    responder();
  endtask

  task automatic do_reset();
    rst_n = 0;
    ack_tgl_a = 0;
    s_valid = 0;
    cycle();
    rst_n = 1;
  endtask

  task automatic wait_done(input string tag, input int budget, output int at_cyc);
    int n = 0;
    at_cyc = -1;
    while (n < budget) begin
      cycle();
      n++;
      if (done) begin
        at_cyc = cyc;
        return;
      end
    end
    check(tag, 0, 1);
  endtask

  initial begin
    int acc_cyc, d_cyc, k, ndone;
    logic [WD-1:0] got_seq[$];
    logic [WD-1:0] want;

    rst_n = 0; s_valid = 0; s_data = '0; ack_tgl_a = 0;
    model_reset();

    // 1: reset held for two edges
    cycle();
    cycle();
    check("t1_data", tx_data, 8'hFF);
    check("t1_req", tx_req, 0);
    check("t1_ready", s_ready, 1);
    check("t1_busy", busy, 0);
    check("t1_done", done, 0);
    rst_n = 1;
    cycle();

    // 2: single transfer with immediate loopback
    loop_en = 1; loop_dly = 0; rem_cnt = 0;
    s_data = 8'hA5; s_valid = 1;
    cycle();
    acc_cyc = cyc;
    s_valid = 0;
    check("t2_data", tx_data, 8'hA5);
    check("t2_req", tx_req, 1);
    wait_done("t2_timeout", 20, d_cyc);
    check("t2_latency", d_cyc - acc_cyc, RANK + 1);
    check("t2_ready", s_ready, 1);
    cycle();

    // 3: back-to-back with s_valid held
    do_reset();
    loop_dly = 3; rem_cnt = 3;
    k = 1; s_data = 8'h01; s_valid = 1; ndone = 0;
    for (int i = 0; i < 100 && ndone < 3; i++) begin
      cycle();
      if (done) begin
        ndone++;
        got_seq.push_back(tx_data);
      end
      if (m_accept) begin
        k++;
        s_data = WD'(k);
        if (k > 3) s_valid = 0;
      end
    end
    check("t3_ndone", ndone, 3);
    for (int i = 0; i < 3; i++) begin
      want = WD'(i + 1);
      check("t3_seq", (i < got_seq.size()) ? got_seq[i] : 8'hXX, want);
    end
    check("t3_req", tx_req, 1);
    s_valid = 0;
    cycle();

    // 4: spurious ack while idle, then an instant completion
    loop_en = 0;
    ack_tgl_a = ~ack_tgl_a;
    ndone = 0;
    repeat (RANK + 3) begin
      cycle();
      if (done) ndone++;
    end
    check("t4_nodone", ndone, 0);
    check("t4_idle", s_ready, 1);
    s_data = 8'h5A; s_valid = 1;
    cycle();
    acc_cyc = cyc;
    s_valid = 0;
    wait_done("t4_timeout", 20, d_cyc);
    check("t4_latency", d_cyc - acc_cyc, 1);
    cycle();

    // 5: reset in the middle of a wait
    s_data = 8'h3C; s_valid = 1;
    cycle();
    s_valid = 0;
    cycle();
    check("t5_busy", busy, 1);
    do_reset();
    check("t5_req", tx_req, 0);
    check("t5_busy_rst", busy, 0);
    check("t5_ready", s_ready, 1);
    check("t5_done", done, 0);
    repeat (4) cycle();

`ifdef CDC_LAUNCH_TIMEOUT_EN
    // 6: timeout flag, then a late ack still completes
    s_data = 8'h77; s_valid = 1;
    cycle();
    s_valid = 0;
    repeat (TMO_MAX - 1) cycle();
    check("t6_err_early", err_tmo, 0);
    cycle();
    check("t6_err_set", err_tmo, 1);
    repeat (5) cycle();
    ack_tgl_a = tx_req;
    wait_done("t6_timeout", 20, d_cyc);
    check("t6_err_sticky", err_tmo, 1);
    do_reset();
    cycle();
`endif

    // Randomized traffic with random remote latency and occasional resets
    loop_en = 1; rand_dly = 1;
    for (int i = 0; i < 3000; i++) begin
      s_valid = 1'($urandom_range(0, 1));
      s_data  = WD'($urandom);
      if ($urandom_range(0, 299) == 0) begin
        rst_n = 0;
        ack_tgl_a = 0;
      end else begin
        rst_n = 1;
      end
      cycle();
    end
    s_valid = 0; rst_n = 1;
    repeat (20) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
